// File: rtl/keypad_scan_ctrl_if.sv
// Key event channel between the keypad controller and its consumer.
// An event is transferred on a rising edge where key_valid && key_ready.
interface keypad_scan_ctrl_if;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_ready;

    modport master (output key_code, output key_valid, input key_ready);
    modport slave  (input key_code, input key_valid, output key_ready);
endinterface

// File: rtl/keypad_scan_ctrl.sv
// 4x4 matrix keypad controller: column scan, row synchronizer, press/release
// debounce and a single-entry valid/ready key event register.
module keypad_scan_ctrl #(
    parameter int CLK_HZ      = 27_000_000,
    parameter int COL_SCAN_HZ = 1000,
    parameter int DEBOUNCE_MS = 10
) (
    input  logic                      clk,
    input  logic                      n_reset,
    input  logic [3:0]                filas_raw,
    output logic [3:0]                columnas,
    keypad_scan_ctrl_if.master        key_out
);
    localparam int STEP_CYCLES = CLK_HZ / (COL_SCAN_HZ * 4);
    localparam int DB_CYCLES   = (CLK_HZ / 1000) * DEBOUNCE_MS;
    localparam int SW          = $clog2(STEP_CYCLES);
    localparam int DW          = $clog2(DB_CYCLES);
    localparam logic [SW-1:0] STEP_LAST = SW'(STEP_CYCLES - 1);
    localparam logic [DW-1:0] DB_LAST   = DW'(DB_CYCLES - 1);

    typedef enum logic [1:0] {SCAN, DEBOUNCE, EMIT, WAIT_RELEASE} state_t;

    state_t          state_reg, state_next;
    logic [3:0]      rows_meta_reg, rows_s;
    logic [1:0]      col_reg, col_next;
    logic [SW-1:0]   step_reg, step_next;
    logic [DW-1:0]   db_reg, db_next;
    logic [3:0]      lat_rows_reg, lat_rows_next;
    logic [3:0]      key_code_reg, key_code_next;
    logic            key_valid_reg, key_valid_next;
    logic            one_hot;
    logic            slot_free;

    function automatic logic [3:0] map_key(input logic [1:0] col, input logic [3:0] rows);
        logic [1:0] r;
        logic [3:0] code;
        r = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (rows[i]) r = 2'(i);
        end
        case ({col, r})
            4'h0: code = 4'h7;  4'h1: code = 4'h4;  4'h2: code = 4'h1;  4'h3: code = 4'hE;
            4'h4: code = 4'h8;  4'h5: code = 4'h5;  4'h6: code = 4'h2;  4'h7: code = 4'h0;
            4'h8: code = 4'h9;  4'h9: code = 4'h6;  4'hA: code = 4'h3;  4'hB: code = 4'hF;
            4'hC: code = 4'hA;  4'hD: code = 4'hB;  4'hE: code = 4'hC;  default: code = 4'hD;
        endcase
        return code;
    endfunction

    // Column drive is a pure decode of the current column, so it can never be all-zero.
    for (genvar gi = 0; gi < 4; gi++) begin : g_col
        assign columnas[gi] = (col_reg == 2'(gi));
    end

    assign key_out.key_code  = key_code_reg;
    assign key_out.key_valid = key_valid_reg;

    assign one_hot   = (rows_s != 4'd0) && ((rows_s & (rows_s - 4'd1)) == 4'd0);
    assign slot_free = !key_valid_reg || key_out.key_ready;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_reg     <= SCAN;
            rows_meta_reg <= 4'd0;
            rows_s        <= 4'd0;
            col_reg       <= 2'd0;
            step_reg      <= '0;
            db_reg        <= '0;
            lat_rows_reg  <= 4'd0;
            key_code_reg  <= 4'd0;
            key_valid_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            rows_meta_reg <= filas_raw;
            rows_s        <= rows_meta_reg;
            col_reg       <= col_next;
            step_reg      <= step_next;
            db_reg        <= db_next;
            lat_rows_reg  <= lat_rows_next;
            key_code_reg  <= key_code_next;
            key_valid_reg <= key_valid_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        col_next       = col_reg;
        step_next      = step_reg;
        db_next        = db_reg;
        lat_rows_next  = lat_rows_reg;
        key_code_next  = key_code_reg;
        key_valid_next = key_valid_reg;

        // Consumer handshake; an EMIT load below on the same edge overrides the clear.
        if (key_valid_reg && key_out.key_ready) key_valid_next = 1'b0;

        case (state_reg)
            SCAN: begin
                if (step_reg == STEP_LAST) begin
                    if (one_hot) begin
                        lat_rows_next = rows_s;
                        db_next       = '0;
                        state_next    = DEBOUNCE;
                    end else begin
                        col_next  = col_reg + 2'd1;
                        step_next = '0;
                    end
                end else begin
                    step_next = step_reg + SW'(1);
                end
            end
            DEBOUNCE: begin
                if (rows_s != lat_rows_reg) begin
                    state_next = SCAN;
                    col_next   = col_reg + 2'd1;
                    step_next  = '0;
                end else if (db_reg == DB_LAST) begin
                    state_next = EMIT;
                end else begin
                    db_next = db_reg + DW'(1);
                end
            end
            EMIT: begin
                if (slot_free) begin
                    key_code_next  = map_key(col_reg, lat_rows_reg);
                    key_valid_next = 1'b1;
                    db_next        = '0;
                    state_next     = WAIT_RELEASE;
                end
            end
            default: begin
                if (rows_s != 4'd0) begin
                    db_next = '0;
                end else if (db_reg == DB_LAST) begin
                    state_next = SCAN;
                    col_next   = col_reg + 2'd1;
                    step_next  = '0;
                end else begin
                    db_next = db_reg + DW'(1);
                end
            end
        endcase
    end
endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Randomized and directed bench for keypad_scan_ctrl with a behavioural keypad
// and an event scoreboard built from the key layout.
module tb_keypad_scan_ctrl;
    logic       clk;
    logic       n_reset;
    logic [3:0] filas_raw;
    logic [3:0] columnas;
    logic [15:0] pressed;   // bit c*4+r: key at column c, row r is held down
    int errors = 0;
    int checks = 0;
    bit chk_en = 0;
    bit rand_done = 0;
    logic [3:0] exp_q[$];
    logic [3:0] layout [16];
    logic       prev_v, prev_r;
    logic [3:0] prev_c;

    keypad_scan_ctrl_if kif();

    keypad_scan_ctrl #(.CLK_HZ(4000), .COL_SCAN_HZ(100), .DEBOUNCE_MS(2)) dut (
        .clk(clk), .n_reset(n_reset), .filas_raw(filas_raw),
        .columnas(columnas), .key_out(kif)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    // Physical keypad: a row reads high when a pressed key sits on a driven column.
    always_comb begin
        filas_raw = 4'd0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                if (pressed[c*4 + r] && columnas[c]) filas_raw[r] = 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Continuous protocol checks plus the event scoreboard.
    always @(negedge clk) begin
        if (!n_reset) begin
            prev_v <= 1'b0;
            prev_r <= 1'b0;
            prev_c <= 4'd0;
        end else begin
            check("col_onehot", $countones(columnas), 1);
            if (prev_v && !prev_r) begin
                check("hold_valid", kif.key_valid, 1);
                check("hold_code", kif.key_code, prev_c);
            end
            if (kif.key_valid && kif.key_ready) begin
                $display("event code=%h t=%0t", kif.key_code, $time);
                if (chk_en) begin
                    if (exp_q.size() == 0) check("rand_extra", 1, 0);
                    else check("rand_code", kif.key_code, exp_q.pop_front());
                end
            end
            prev_v <= kif.key_valid;
            prev_r <= kif.key_ready;
            prev_c <= kif.key_code;
        end
    end

    task automatic wait_col_start(input logic [3:0] c);
        logic [3:0] last;
        bit ok;
        ok = 0;
        @(negedge clk);
        last = columnas;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (columnas == c && last != c) ok = 1;
            else last = columnas;
        end
        if (!ok) check("wait_col_timeout", 0, 1);
    endtask

    task automatic wait_valid(input int max, output int n);
        bit ok;
        ok = 0;
        n = 0;
        for (int i = 0; i < max && !ok; i++) begin
            @(negedge clk);
            n++;
            if (kif.key_valid) ok = 1;
        end
        if (!ok) check("valid_timeout", 0, 1);
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1 n_reset = 1;
    endtask

    initial begin
        int n, pulses;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) layout[c*4 + r] = 4'h0;
        // Printed keypad, top row first: 7 8 9 A / 4 5 6 B / 1 2 3 C / E 0 F D
        layout[0] = 4'h7; layout[4] = 4'h8; layout[8]  = 4'h9; layout[12] = 4'hA;
        layout[1] = 4'h4; layout[5] = 4'h5; layout[9]  = 4'h6; layout[13] = 4'hB;
        layout[2] = 4'h1; layout[6] = 4'h2; layout[10] = 4'h3; layout[14] = 4'hC;
        layout[3] = 4'hE; layout[7] = 4'h0; layout[11] = 4'hF; layout[15] = 4'hD;

        pressed = 16'd0;
        kif.key_ready = 1'b1;
        n_reset = 1'b0;
        #1;
        check("rst_col", columnas, 4'b0001);
        check("rst_valid", kif.key_valid, 0);
        check("rst_code", kif.key_code, 0);
        repeat (3) @(posedge clk);
        #1 n_reset = 1'b1;

        // 1: free-running scan, 10 cycles per column
        for (int k = 0; k <= 40; k++) begin
            @(negedge clk);
            if (k % 5 == 0) begin
                check("scan_col", columnas, 4'b0001 << ((k / 10) % 4));
                check("scan_valid", kif.key_valid, 0);
            end
        end

        // 2: hold (col1,row2) 200 cycles -> one event after DB+2 from the sample
        wait_col_start(4'b0010);
        pressed[1*4 + 2] = 1'b1;
        wait_valid(60, n);
        check("latency", n, 19);
        check("code_2", kif.key_code, 4'h2);
        pulses = 1;
        @(negedge clk);
        check("pulse_1cyc", kif.key_valid, 0);
        for (int i = 0; i < 180; i++) begin
            @(negedge clk);
            if (kif.key_valid) pulses++;
        end
        check("no_repeat", pulses, 1);
        pressed = 16'd0;
        pulses = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (kif.key_valid) pulses++;
        end
        check("no_release_event", pulses, 0);
        pressed[1*4 + 2] = 1'b1;
        wait_valid(60, n);
        check("repress_code", kif.key_code, 4'h2);
        pressed = 16'd0;
        repeat (30) @(negedge clk);

        // 3: 4-cycle bounce on (col2,row3)
        wait_col_start(4'b0100);
        repeat (6) @(negedge clk);
        pressed[2*4 + 3] = 1'b1;
        repeat (4) @(negedge clk);
        pressed = 16'd0;
        @(negedge clk);
        check("db_col_held", columnas, 4'b0100);
        repeat (3) @(negedge clk);
        check("abort_advance", columnas, 4'b1000);
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (kif.key_valid) pulses++;
        end
        check("bounce_no_event", pulses, 0);

        // 4: consumer stalled; second key waits in EMIT, then reloads on the accept edge
        kif.key_ready = 1'b0;
        wait_col_start(4'b0001);
        pressed[0] = 1'b1;
        wait_valid(60, n);
        check("code_7", kif.key_code, 4'h7);
        pressed = 16'd0;
        repeat (30) @(negedge clk);
        pressed[1*4 + 1] = 1'b1;
        repeat (80) @(negedge clk);
        check("stall_valid", kif.key_valid, 1);
        check("stall_code", kif.key_code, 4'h7);
        check("stall_col", columnas, 4'b0010);
        kif.key_ready = 1'b1;
        @(negedge clk);
        check("reload_valid", kif.key_valid, 1);
        check("reload_code", kif.key_code, 4'h5);
        @(negedge clk);
        check("reload_drain", kif.key_valid, 0);
        pressed = 16'd0;
        repeat (30) @(negedge clk);

        // 5: two rows on column 3 are ignored until one is released
        pressed[12] = 1'b1;
        pressed[13] = 1'b1;
        pulses = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (kif.key_valid) pulses++;
        end
        check("multi_no_event", pulses, 0);
        pressed[13] = 1'b0;
        wait_valid(60, n);
        check("code_A", kif.key_code, 4'hA);
        pressed = 16'd0;
        repeat (30) @(negedge clk);

        // 6: asynchronous reset during DEBOUNCE and during WAIT_RELEASE
        wait_col_start(4'b0100);
        pressed[8] = 1'b1;
        repeat (13) @(negedge clk);
        #2 n_reset = 1'b0;
        #1;
        check("arst_db_col", columnas, 4'b0001);
        check("arst_db_valid", kif.key_valid, 0);
        check("arst_db_code", kif.key_code, 0);
        repeat (3) @(posedge clk);
        #1 n_reset = 1'b1;
        wait_valid(80, n);
        check("code_9", kif.key_code, 4'h9);
        repeat (5) @(negedge clk);
        check("wr_col_held", columnas, 4'b0100);
        #2 n_reset = 1'b0;
        #1;
        check("arst_wr_col", columnas, 4'b0001);
        check("arst_wr_code", kif.key_code, 0);
        pressed = 16'd0;
        release_reset();
        @(negedge clk);
        check("restart_col0", columnas, 4'b0001);
        repeat (10) @(negedge clk);
        check("restart_col1", columnas, 4'b0010);
        repeat (20) @(negedge clk);

        // Randomized presses with a randomly stalling consumer
        chk_en = 1;
        fork
            begin
                for (int t = 0; t < 30; t++) begin
                    int idx;
                    idx = $urandom_range(0, 15);
                    repeat ($urandom_range(0, 20)) @(negedge clk);
                    exp_q.push_back(layout[idx]);
                    pressed[idx] = 1'b1;
                    repeat ($urandom_range(70, 120)) @(negedge clk);
                    pressed = 16'd0;
                    repeat ($urandom_range(30, 45)) @(negedge clk);
                end
                rand_done = 1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk);
                    #1 kif.key_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        kif.key_ready = 1'b1;
        repeat (50) @(negedge clk);
        check("rand_all_seen", exp_q.size(), 0);
        chk_en = 0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
